// File: rtl/uart_rx_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_pkg
// Brief   : Shared UART constants and receiver state encoding.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // 115200 baud from a 12 MHz clock; shared with the transmitter
    localparam int DEFAULT_CLOCKS_PER_BAUD = 104;

    // 8N1 frame shape
    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync2.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_sync2
// Brief   : Two-flop synchronizer for an asynchronous single-bit input.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Two stages; the reset value should match the pin's idle level
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            meta <= RESET_VALUE;
            q_o  <= RESET_VALUE;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module  : uart_rx
// Brief   : 8N1 UART receiver with mid-bit sampling, one-cycle valid and
//           frame-error strobes, and break detection.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_error_o,
    output logic       busy_o
);

    localparam int HALF_BAUD = CLOCKS_PER_BAUD / 2;
    localparam int CNT_W     = $clog2(CLOCKS_PER_BAUD);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BAUD - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t      state;
    uart_state_t      next_state;
    logic             rx_s;
    logic             tick;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic             frame_error_next;

    uart_rx_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (rx_i),
        .q_o     (rx_s)
    );

    assign tick = (baud_cnt == '0);

    // State and datapath registers; busy follows the state it will be in
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_error_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state         <= next_state;
            baud_cnt      <= baud_cnt_next;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            data_o        <= data_next;
            valid_o       <= valid_next;
            frame_error_o <= frame_error_next;
            busy_o        <= (next_state != ST_IDLE);
        end
    end

    // Next-state decision, driven only by the synchronized line and ticks
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!rx_s) next_state = ST_START;
            ST_START: if (tick) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && (bit_cnt == LAST_BIT)) next_state = ST_STOP;
            ST_STOP:  if (tick) next_state = (rx_s == STOP_LEVEL) ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Counter loads, bit shifting and the one-cycle strobes
    always_comb begin
        baud_cnt_next    = tick ? baud_cnt : baud_cnt - 1'b1;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        data_next        = data_o;
        valid_next       = 1'b0;
        frame_error_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) baud_cnt_next = HALF_LOAD;
            end
            ST_START: begin
                if (tick && !rx_s) begin
                    baud_cnt_next = FULL_LOAD;
                    bit_cnt_next  = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top
                    shift_next    = {rx_s, shift_reg[7:1]};
                    baud_cnt_next = FULL_LOAD;
                    bit_cnt_next  = bit_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s == STOP_LEVEL) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLOCKS_PER_BAUD (CPB)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .rx_i          (rx),
        .data_o        (data),
        .valid_o       (valid),
        .frame_error_o (fe),
        .busy_o        (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Strobe monitor
    int         valid_cnt = 0;
    int         fe_cnt    = 0;
    int         busy_cnt  = 0;
    int         both_cnt  = 0;
    int         valid_cyc = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            rxq.push_back(data);
        end
        if (fe === 1'b1)   fe_cnt   = fe_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (valid === 1'b1 && fe === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int start_cyc = 0;

    // Caller is at posedge+1; returns at posedge+1 with zero idle gap
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (i == 0) start_cyc = cyc;
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    // Sends 0x7E and pulses reset half-way through data bit 4
    task automatic abort_frame(input int p);
        logic [9:0] f;
        f = {1'b1, 8'h7E, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat ((i == 4) ? p / 2 : p) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
    endtask

    int vb, fb, qb;
    int periods[3] = '{104, 101, 107};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data",  32'(data),  32'h00);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_fe",    32'(fe),    32'h0);
        check_eq("rst_busy",  32'(busy),  32'h0);
        rst = 1'b0;

        // Idle line for 2000 cycles
        repeat (2000) @(posedge clk);
        #1;
        check_eq("idle_valid", 32'(valid_cnt), 32'd0);
        check_eq("idle_fe",    32'(fe_cnt),    32'd0);
        check_eq("idle_busy",  32'(busy_cnt),  32'd0);
        check_eq("idle_data",  32'(data),      32'h00);

        // Single 0x41 frame with strobe timing
        send_frame(8'h41, 1'b1, CPB);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b41_count", 32'(valid_cnt), 32'd1);
        check_eq("b41_data",  32'(data),      32'h41);
        check_eq("b41_time",  32'(valid_cyc), 32'(start_cyc + 3 + 52 + 936));

        // Back-to-back frames, no idle between them
        qb = rxq.size();
        vb = valid_cnt;
        send_frame(8'h55, 1'b1, CPB);
        send_frame(8'hAA, 1'b1, CPB);
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_count", 32'(valid_cnt - vb), 32'd4);
        if (rxq.size() >= qb + 4) begin
            check_eq("b2b_0", 32'(rxq[qb]),     32'h55);
            check_eq("b2b_1", 32'(rxq[qb + 1]), 32'hAA);
            check_eq("b2b_2", 32'(rxq[qb + 2]), 32'h00);
            check_eq("b2b_3", 32'(rxq[qb + 3]), 32'hFF);
        end
        check_eq("b2b_fe", 32'(fe_cnt), 32'd0);

        // 30-cycle glitch on an idle line
        vb = valid_cnt;
        rx = 1'b0;
        start_cyc = cyc;
        repeat (30) @(posedge clk);
        #1;
        rx = 1'b1;
        while (cyc < start_cyc + 3 + 51) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy), 32'h1);
        while (cyc < start_cyc + 3 + 53) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("glitch_valid", 32'(valid_cnt - vb), 32'd0);
        check_eq("glitch_fe",    32'(fe_cnt),         32'd0);

        // Stop bit low, then held low as a break
        vb = valid_cnt;
        send_frame(8'h5A, 1'b0, CPB);
        rx = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("brk_fe",    32'(fe_cnt),         32'd1);
        check_eq("brk_valid", 32'(valid_cnt - vb), 32'd0);
        check_eq("brk_data",  32'(data),           32'hFF);
        check_eq("brk_busy",  32'(busy),           32'h0);
        send_frame(8'h33, 1'b1, CPB);
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_brk_count", 32'(valid_cnt - vb), 32'd1);
        check_eq("post_brk_data",  32'(data),           32'h33);

        // Reset mid-frame, then a good frame, at nominal and +/-3% periods
        for (int k = 0; k < 3; k++) begin
            vb = valid_cnt;
            fb = fe_cnt;
            abort_frame(periods[k]);
            check_eq($sformatf("abort_data_%0d", periods[k]), 32'(data),  32'h00);
            check_eq($sformatf("abort_busy_%0d", periods[k]), 32'(busy),  32'h0);
            repeat (2 * CPB) @(posedge clk);
            #1;
            check_eq($sformatf("abort_valid_%0d", periods[k]), 32'(valid_cnt - vb), 32'd0);
            send_frame(8'h12, 1'b1, periods[k]);
            repeat (20) @(posedge clk);
            #1;
            check_eq($sformatf("rx12_count_%0d", periods[k]), 32'(valid_cnt - vb), 32'd1);
            check_eq($sformatf("rx12_data_%0d", periods[k]),  32'(data),           32'h12);
            check_eq($sformatf("rx12_fe_%0d", periods[k]),    32'(fe_cnt - fb),    32'd0);
        end

        check_eq("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
